pe_sat_accumulator: RTL
=======================

# pe_sat_accumulator

Sequential reduction stage that sits directly downstream of the PE ALU add/sub datapath. It folds a stream of `num_terms` signed LEN-bit operands into one saturating running result and emits the final value with a sticky saturation flag. Input and output are valid/ready handshakes, so the PE controller can stall either side.

## Interface
- `LEN`, 9, operand/result width, two's complement.
- `CNT_W`, 8, width of the term counter and of `num_terms`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a reduction; sampled only in IDLE.
- `num_terms`  in  CNT_W  number of operands to accumulate; sampled with `start`.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block accepts operand beats.
- `in_data`  in  LEN  signed operand.
- `in_sub`  in  1  per-beat op: 0 = acc + in_data, 1 = acc − in_data.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_data`  out  LEN  final signed accumulated result.
- `out_sat`  out  1  set if any beat of this reduction saturated.
- `busy`  out  1  high in ACC and HOLD.

## Operation
- FSM states: IDLE, ACC, HOLD. Reset enters IDLE.
- **IDLE**
  - `in_ready=0`, `out_valid=0`.
  - On `start`: latch `num_terms`, clear acc to 0, clear the sat flag, clear count.
  - Go to ACC if `num_terms != 0`; otherwise go to HOLD with result 0 and `out_sat=0`.
- **ACC**
  - `in_ready=1`.
  - Each accepted beat (`in_valid & in_ready`): compute a LEN+1-bit signed acc ± `in_data` (both operands sign-extended).
    - If the result exceeds 2^(LEN-1)−1, load 2^(LEN-1)−1.
    - If it is below −2^(LEN-1), load −2^(LEN-1).
    - Otherwise load the low LEN bits.
  - Saturation sets the sticky flag. Later beats continue from the clamped value.
  - Count increments on every accepted beat. The beat that makes count equal `num_terms` moves the FSM to HOLD.
  - `in_valid` low: no state change (bubbles allowed).
- **HOLD**
  - `out_valid=1`; `out_data` and `out_sat` are stable.
  - On `out_ready`: go to IDLE.
- `start` asserted in ACC or HOLD is ignored, with no queuing.
- `start` in IDLE while a previous result is still pending is not possible, because HOLD blocks the return to IDLE.
- Bit patterns in `in_data` with `in_sub=1` and value −2^(LEN-1) are handled by the widened arithmetic; no special case is needed.

## Timing
- Reset values: `in_ready=0`, `out_valid=0`, `out_data=0`, `out_sat=0`, `busy=0`. Acc, count and the latched `num_terms` are 0.
- `in_ready`, `out_valid` and `busy` decode from registered state only. They have no combinational path from `in_valid` or `out_ready`.
- `start` in cycle t gives `in_ready=1` at t+1.
- The last beat accepted in cycle t gives `out_valid=1` with the final value at t+1.
- `out_ready` in HOLD at cycle t gives IDLE at t+1, and a new `start` can be accepted at t+1.
- With `num_terms=0`, `start` at t gives `out_valid` at t+1.
- Throughput: one beat per cycle in ACC. Minimum reduction turnaround is N+2 cycles with `out_ready` held high.
- `rstn` low at any point, including mid-ACC or in HOLD, immediately forces IDLE and the reset values. The partial result is discarded.

## Structure
- Shared PE package holds:
  - FSM state encoding (IDLE/ACC/HOLD);
  - the saturation limit constants derived from LEN (`SAT_MAX`, `SAT_MIN`).
- One combinational sub-module, `sat_addsub`:
  - inputs: a, b (LEN each) and sub;
  - outputs: the saturated LEN-bit result and a sat flag.
- The top level holds the FSM, counter, acc register and handshake logic.

## Test plan
- Add 100, 100, 50 (`num_terms=3`, `in_sub=0`) -> `out_data=250`, `out_sat=0`, `out_valid` one cycle after the third beat.
- Add 200 then 100 -> `out_data=255` (0x0FF), `out_sat=1`. Then add −200 then −100 in a new reduction -> `out_data=−256` (0x100), `out_sat=1` (negative+negative overflow must clamp).
- Sub: beats 0 (sub), −256 (sub) -> 0 − (−256) clamps to 255, `out_sat=1`. Then 255 with `in_sub=1` added as a third beat -> 0, `out_sat` stays 1.
- Backpressure: 4 beats with `in_valid` toggling every other cycle and `out_ready` held low 5 cycles.
  - Expected: beats accepted only when valid; `out_valid` and `out_data` held stable 5 cycles.
  - Expected: `start` pulsed during ACC and HOLD is ignored.
  - Expected: IDLE one cycle after `out_ready`.
- `num_terms=0` -> `out_valid` at t+1 with `out_data=0`, `out_sat=0`, and `in_ready` never asserted.
- Assert `rstn` low after 2 of 5 beats -> `in_ready`, `out_valid` and `busy` drop asynchronously. After release the block is in IDLE, and a new 1-term reduction of 7 returns 7.

Source files
------------

// File: rtl/pe_sat_accumulator_pkg.sv
// Shared PE definitions: reduction FSM encoding and saturation limits derived from the width.
package pe_sat_accumulator_pkg;

    localparam int unsigned PE_LEN   = 9;
    localparam int unsigned PE_CNT_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StHold
    } accState_t;

    function automatic int satMax(input int unsigned len);
        return (1 << (len - 1)) - 1;
    endfunction

    function automatic int satMin(input int unsigned len);
        return -(1 << (len - 1));
    endfunction

    localparam int SAT_MAX = satMax(PE_LEN);
    localparam int SAT_MIN = satMin(PE_LEN);

endpackage

// File: rtl/pe_sat_accumulator_sat_addsub.sv
// Saturating signed add/sub: a +/- b evaluated one bit wider, then clamped to the LEN-bit range.
module sat_addsub
    import pe_sat_accumulator_pkg::*;
#(
    parameter int unsigned LEN = PE_LEN
) (
    input  logic [LEN-1:0] a,
    input  logic [LEN-1:0] b,
    input  logic           sub,
    output logic [LEN-1:0] result,
    output logic           sat
);

    localparam logic signed [LEN:0] MaxWide = (LEN + 1)'(satMax(LEN));
    localparam logic signed [LEN:0] MinWide = (LEN + 1)'(satMin(LEN));

    logic signed [LEN:0] aExt;
    logic signed [LEN:0] bExt;
    logic signed [LEN:0] wide;

    always_comb begin
        aExt   = {a[LEN-1], a};
        bExt   = {b[LEN-1], b};
        wide   = sub ? (aExt - bExt) : (aExt + bExt);
        result = wide[LEN-1:0];
        sat    = 1'b0;
        if (wide > MaxWide) begin
            result = MaxWide[LEN-1:0];
            sat    = 1'b1;
        end else if (wide < MinWide) begin
            result = MinWide[LEN-1:0];
            sat    = 1'b1;
        end
    end

endmodule

// File: rtl/pe_sat_accumulator.sv
// Folds num_terms signed operands into one saturating result with a sticky saturation flag.
module pe_sat_accumulator
    import pe_sat_accumulator_pkg::*;
#(
    parameter int unsigned LEN   = PE_LEN,
    parameter int unsigned CNT_W = PE_CNT_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [CNT_W-1:0] num_terms,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LEN-1:0]   in_data,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LEN-1:0]   out_data,
    output logic             out_sat,
    output logic             busy
);

    accState_t        stateQ, stateD;
    logic [LEN-1:0]   accQ, accD;
    logic             satQ, satD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic [CNT_W-1:0] numTermsQ, numTermsD;

    logic [LEN-1:0]   sumRes;
    logic             sumSat;
    logic             beat;
    logic             lastBeat;

    sat_addsub #(
        .LEN(LEN)
    ) uAddSub (
        .a     (accQ),
        .b     (in_data),
        .sub   (in_sub),
        .result(sumRes),
        .sat   (sumSat)
    );

    // in_ready is a pure state decode, so this never loops back through in_valid.
    assign beat     = in_valid & in_ready;
    assign lastBeat = (cntQ + CNT_W'(1)) == numTermsQ;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stateQ    <= StIdle;
            accQ      <= '0;
            satQ      <= 1'b0;
            cntQ      <= '0;
            numTermsQ <= '0;
        end else begin
            stateQ    <= stateD;
            accQ      <= accD;
            satQ      <= satD;
            cntQ      <= cntD;
            numTermsQ <= numTermsD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: begin
                if (start) begin
                    stateD = (num_terms != '0) ? StAcc : StHold;
                end
            end
            StAcc: begin
                if (beat && lastBeat) begin
                    stateD = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        accD      = accQ;
        satD      = satQ;
        cntD      = cntQ;
        numTermsD = numTermsQ;
        if (stateQ == StIdle && start) begin
            accD      = '0;
            satD      = 1'b0;
            cntD      = '0;
            numTermsD = num_terms;
        end else if (beat) begin
            accD = sumRes;
            satD = satQ | sumSat;
            cntD = cntQ + CNT_W'(1);
        end
    end

    always_comb begin
        in_ready  = (stateQ == StAcc);
        out_valid = (stateQ == StHold);
        busy      = (stateQ != StIdle);
        out_data  = accQ;
        out_sat   = satQ;
    end

endmodule
